// File: rtl/keypad_pkg.sv
// keypad_pkg: scanner state type, special key codes, matrix lookup and BCD conversion
// shared by the keypad scanner and the entry register.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} scan_state_e;

    localparam logic [3:0] KEY_BKSP  = 4'hA;
    localparam logic [3:0] KEY_CLR   = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hC;

    // Physical layout: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hE;
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [13:0] bcd_to_bin(input logic [15:0] bcd);
        return 14'(bcd[15:12]) * 14'd1000 + 14'(bcd[11:8]) * 14'd100
             + 14'(bcd[7:4]) * 14'd10 + 14'(bcd[3:0]);
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// keypad_scan: drives the keypad rows, detects a single pressed key and debounces
// both press and release, emitting one key_valid pulse per accepted press.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 50_000,
    parameter int DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [3:0] key_col,
    output logic [3:0] key_row,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    scan_state_e      state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DB_W-1:0]  db_q, db_d;
    logic [1:0]       row_q, row_d, col_q, col_d;
    logic [3:0]       pat_q, pat_d, code_q, code_d;
    logic             valid_q, valid_d;
    logic [3:0]       col_s1_q, col_s2_q;
    logic [1:0]       col_idx;
    logic             one_low, all_high, col_match;

    // The columns come straight off the pads, so bring them into the clock domain first.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            col_s1_q <= 4'hF;
            col_s2_q <= 4'hF;
        end else begin
            col_s1_q <= key_col;
            col_s2_q <= col_s1_q;
        end
    end

    assign all_high  = col_s2_q == 4'hF;
    assign one_low   = $countones(~col_s2_q) == 1;
    assign col_match = col_s2_q == pat_q;
    assign col_idx   = !col_s2_q[0] ? 2'd0 : !col_s2_q[1] ? 2'd1 : !col_s2_q[2] ? 2'd2 : 2'd3;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        db_d    = db_q;
        row_d   = row_q;
        col_d   = col_q;
        pat_d   = pat_q;
        code_d  = code_q;
        valid_d = 1'b0;
        case (state_q)
            SCAN: begin
                div_d = div_q + 1'b1;
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (one_low) begin
                        state_d = DEBOUNCE;
                        col_d   = col_idx;
                        pat_d   = col_s2_q;
                        db_d    = '0;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            DEBOUNCE: begin
                if (!col_match) begin
                    state_d = SCAN;
                    db_d    = '0;
                    div_d   = '0;
                    row_d   = row_q + 1'b1;
                end else if (db_q == DB_LAST) begin
                    state_d = HOLD;
                    db_d    = '0;
                    code_d  = key_lookup(row_q, col_q);
                    valid_d = 1'b1;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            HOLD: begin
                if (all_high) begin
                    state_d = RELEASE;
                    db_d    = '0;
                end
            end
            RELEASE: begin
                if (!all_high) begin
                    db_d = '0;
                end else if (db_q == DB_LAST) begin
                    state_d = SCAN;
                    db_d    = '0;
                    div_d   = '0;
                    row_d   = row_q + 1'b1;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= SCAN;
            div_q   <= '0;
            db_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            pat_q   <= 4'hF;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            db_q    <= db_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pat_q   <= pat_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign key_row   = ~(4'b0001 << row_q);
    assign key_valid = valid_q;
    assign key_code  = code_q;

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: keypad scanner plus the BCD digit-entry register and its registered
// binary conversion feeding the setting logic.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 50_000,
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int MAX_DIGITS      = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  key_col,
    output logic [3:0]  key_row,
    input  logic        entry_clr,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        enter,
    output logic [15:0] digits,
    output logic [2:0]  digit_cnt,
    output logic [13:0] temp_data
);

    localparam logic [2:0] CNT_MAX = 3'(MAX_DIGITS);

    logic [15:0] digits_q, digits_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        enter_q, enter_d;
    logic [13:0] temp_q, temp_d;
    logic        is_digit;

    keypad_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_scan (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .key_col  (key_col),
        .key_row  (key_row),
        .key_valid(key_valid),
        .key_code (key_code)
    );

    assign is_digit = key_code <= 4'd9;

    // entry_clr wins over a coincident key; ENTER still reports because it carries no entry effect.
    always_comb begin
        digits_d = digits_q;
        cnt_d    = cnt_q;
        if (entry_clr || (key_valid && key_code == KEY_CLR)) begin
            digits_d = '0;
            cnt_d    = '0;
        end else if (key_valid && is_digit && cnt_q < CNT_MAX) begin
            digits_d = {digits_q[11:0], key_code};
            cnt_d    = cnt_q + 1'b1;
        end else if (key_valid && key_code == KEY_BKSP && cnt_q != '0) begin
            digits_d = {4'h0, digits_q[15:4]};
            cnt_d    = cnt_q - 1'b1;
        end
        enter_d = key_valid && key_code == KEY_ENTER;
        temp_d  = bcd_to_bin(digits_q);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            digits_q <= '0;
            cnt_q    <= '0;
            enter_q  <= 1'b0;
            temp_q   <= '0;
        end else begin
            digits_q <= digits_d;
            cnt_q    <= cnt_d;
            enter_q  <= enter_d;
            temp_q   <= temp_d;
        end
    end

    assign digits    = digits_q;
    assign digit_cnt = cnt_q;
    assign enter     = enter_q;
    assign temp_data = temp_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed and random key presses on a modelled 4x4 matrix, checked
// against a digit-queue reference model of the entry register.
module tb_keypad_entry;

    localparam int SD = 4;
    localparam int DB = 20;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [3:0]  key_col;
    logic [3:0]  key_row;
    logic        entry_clr = 1'b0;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        enter;
    logic [15:0] digits;
    logic [2:0]  digit_cnt;
    logic [13:0] temp_data;

    logic [15:0] held = '0;
    int km [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    int q[$];
    int checks = 0;
    int errors = 0;
    int vcnt = 0;
    int ecnt = 0;
    int erun = 0;
    int emax = 0;
    int exp_enter = 0;

    keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB), .MAX_DIGITS(4)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .key_col  (key_col),
        .key_row  (key_row),
        .entry_clr(entry_clr),
        .key_valid(key_valid),
        .key_code (key_code),
        .enter    (enter),
        .digits   (digits),
        .digit_cnt(digit_cnt),
        .temp_data(temp_data)
    );

    always #5 sys_clk = ~sys_clk;

    // Matrix: a held key pulls its column low while its row is driven low.
    always_comb begin
        key_col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[r*4+c] && !key_row[r]) key_col[c] = 1'b0;
    end

    always begin
        @(posedge sys_clk);
        #2;
        if (key_valid) vcnt++;
        if (enter) begin
            ecnt++;
            erun++;
        end else begin
            erun = 0;
        end
        if (erun > emax) emax = erun;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_digits();
        logic [15:0] f = '0;
        foreach (q[i]) f = {f[11:0], 4'(q[i])};
        return f;
    endfunction

    function automatic int exp_val();
        int v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        return v;
    endfunction

    task automatic apply_model(input int code, input bit clr);
        if (code == 12) exp_enter++;
        if (clr || code == 11) q.delete();
        else if (code <= 9) begin
            if (q.size() < 4) q.push_back(code);
        end else if (code == 10) begin
            if (q.size() > 0) void'(q.pop_back());
        end
    endtask

    task automatic press(input int code, input int hold, input bit clr);
        int idx = 0;
        int v0;
        int old_t;
        bit seen = 0;
        for (int i = 0; i < 16; i++) if (km[i] == code) idx = i;
        old_t = exp_val();
        v0 = vcnt;
        held[idx] = 1'b1;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge sys_clk);
            seen = key_valid;
        end
        chk("valid_seen", 32'(seen), 1);
        if (clr) entry_clr = 1'b1;
        apply_model(code, clr);
        @(negedge sys_clk);
        entry_clr = 1'b0;
        chk("valid_pulse", 32'(key_valid), 0);
        chk("digits", 32'(digits), 32'(exp_digits()));
        chk("temp_lat1", 32'(temp_data), 32'(old_t));
        @(negedge sys_clk);
        chk("temp_lat2", 32'(temp_data), 32'(exp_val()));
        chk("key_code", 32'(key_code), 32'(code));
        chk("digit_cnt", 32'(digit_cnt), 32'(q.size()));
        chk("enter_cnt", 32'(ecnt), 32'(exp_enter));
        repeat (hold) @(negedge sys_clk);
        held[idx] = 1'b0;
        repeat (DB + 12) @(negedge sys_clk);
        chk("one_valid", 32'(vcnt), 32'(v0 + 1));
    endtask

    initial begin
        int v0;
        bit seen;
        repeat (3) @(negedge sys_clk);
        chk("rst_row", 32'(key_row), 32'(4'b1110));
        chk("rst_valid", 32'(key_valid), 0);
        chk("rst_code", 32'(key_code), 0);
        chk("rst_enter", 32'(enter), 0);
        chk("rst_digits", 32'(digits), 0);
        chk("rst_cnt", 32'(digit_cnt), 0);
        chk("rst_temp", 32'(temp_data), 0);
        sys_rst = 1'b0;

        press(5, 80, 0);

        press(11, 3, 0);
        for (int k = 1; k <= 5; k++) press(k, 3, 0);
        chk("d1234", 32'(digits), 32'h1234);
        chk("t1234", 32'(temp_data), 1234);

        press(10, 3, 0);
        press(12, 3, 0);
        chk("t123", 32'(temp_data), 123);
        chk("c3", 32'(digit_cnt), 3);

        v0 = vcnt;
        for (int k = 0; k < 9; k++) begin
            held[5] = ~held[5];
            repeat (7) @(negedge sys_clk);
        end
        chk("bounce_quiet", 32'(vcnt), 32'(v0));
        press(5, 3, 0);

        v0 = vcnt;
        held[0] = 1'b1;
        held[1] = 1'b1;
        repeat (100) @(negedge sys_clk);
        held = '0;
        repeat (DB + 12) @(negedge sys_clk);
        chk("multi_ignored", 32'(vcnt), 32'(v0));

        press(7, 3, 1);
        chk("clr_digits", 32'(digits), 0);
        press(2, 3, 0);
        press(12, 3, 1);

        for (int k = 0; k < 14; k++) press(int'($urandom_range(0, 15)), int'($urandom_range(1, 20)), 0);

        press(11, 2, 0);
        press(3, 2, 0);
        v0 = vcnt;
        held[10] = 1'b1;
        seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge sys_clk);
            seen = key_row == 4'b1011;
        end
        chk("row2_reached", 32'(seen), 1);
        repeat (SD + 4) @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        chk("mrst_row", 32'(key_row), 32'(4'b1110));
        chk("mrst_valid", 32'(key_valid), 0);
        chk("mrst_code", 32'(key_code), 0);
        chk("mrst_enter", 32'(enter), 0);
        chk("mrst_digits", 32'(digits), 0);
        chk("mrst_cnt", 32'(digit_cnt), 0);
        chk("mrst_temp", 32'(temp_data), 0);
        held = '0;
        q.delete();
        @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("mrst_no_valid", 32'(vcnt), 32'(v0));
        press(7, 3, 0);
        press(9, 3, 0);
        chk("t79", 32'(temp_data), 79);

        chk("enter_width", 32'(emax), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
